// File: rtl/rele_cmd_writer.sv
// -----------------------------------------------------------------------------
// rele_cmd_writer
//
// Command sequencer in front of the relay pulse stage. A 12-bit relay mask is
// taken over a valid/ready handshake and written to the relay latches as up to
// two byte-wide strobed writes: the low byte with addr[0], the high nibble with
// addr[1]. Each write has a setup phase (data stable, no strobe), a strobe
// phase, and a one-cycle hold so data never moves on the falling strobe edge.
// After the last strobe the block stays busy for RECOVER_CYC cycles, so a new
// write cannot restart the downstream relay timeout while a pulse is running.
//
// Every output is a register decoded from the current state, so outputs follow
// the state register by one cycle.
//
// Ports
//   clk_i        : clock, all logic on the rising edge
//   reset_i      : synchronous, active-high reset
//   cmd_valid_i  : command present
//   cmd_mask_i   : relay mask, bit i drives downstream imp[i]
//   cmd_ready_o  : block can accept (transfer = cmd_valid_i && cmd_ready_o)
//   addr_o       : write strobes, at most one bit high
//   data_o       : write data to the relay stage
//   busy_o       : high whenever the sequencer is not idle
//   done_o       : one-cycle pulse when a command completes
// -----------------------------------------------------------------------------
module rele_cmd_writer #(
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 4,
  parameter int RECOVER_CYC = 1_050_000,
  parameter int CNT_W       = 21
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cmd_valid_i,
  input  logic [11:0] cmd_mask_i,
  output logic        cmd_ready_o,
  output logic [1:0]  addr_o,
  output logic [7:0]  data_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_SETUP_L = 4'd1,
    ST_STRB_L  = 4'd2,
    ST_HOLD_L  = 4'd3,
    ST_SETUP_H = 4'd4,
    ST_STRB_H  = 4'd5,
    ST_HOLD_H  = 4'd6,
    ST_RECOVER = 4'd7,
    ST_DONE    = 4'd8
  } state_e;

  // Residence time of a state minus one; single-cycle states load zero.
  function automatic logic [CNT_W-1:0] load_cnt(input state_e s);
    logic [CNT_W-1:0] v;
    case (s)
      ST_SETUP_L, ST_SETUP_H: v = CNT_W'(SETUP_CYC - 1);
      ST_STRB_L,  ST_STRB_H:  v = CNT_W'(STROBE_CYC - 1);
      ST_RECOVER:             v = CNT_W'(RECOVER_CYC - 1);
      default:                v = {CNT_W{1'b0}};
    endcase
    return v;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]      mask_q, mask_d;
  logic             ready_q, ready_d;
  logic [1:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             xfer_s;
  logic             cnt_zero_s;

  // The handshake is qualified by the registered ready that the source sees.
  assign xfer_s     = cmd_valid_i && ready_q;
  assign cnt_zero_s = (cnt_q == {CNT_W{1'b0}});

  // Next-state, mask capture and shared down-counter.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (xfer_s) begin
          mask_d = cmd_mask_i;
          // Decide on the incoming mask; mask_q only holds it from next cycle.
          if (cmd_mask_i[7:0] != 8'h00) begin
            state_d = ST_SETUP_L;
          end else if (cmd_mask_i[11:8] != 4'h0) begin
            state_d = ST_SETUP_H;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP_L: begin
        if (cnt_zero_s) state_d = ST_STRB_L;
        else            state_d = ST_SETUP_L;
      end
      ST_STRB_L: begin
        if (cnt_zero_s) state_d = ST_HOLD_L;
        else            state_d = ST_STRB_L;
      end
      ST_HOLD_L: begin
        if (mask_q[11:8] != 4'h0) state_d = ST_SETUP_H;
        else                      state_d = ST_RECOVER;
      end
      ST_SETUP_H: begin
        if (cnt_zero_s) state_d = ST_STRB_H;
        else            state_d = ST_SETUP_H;
      end
      ST_STRB_H: begin
        if (cnt_zero_s) state_d = ST_HOLD_H;
        else            state_d = ST_STRB_H;
      end
      ST_HOLD_H: begin
        state_d = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (cnt_zero_s) state_d = ST_DONE;
        else            state_d = ST_RECOVER;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reload on every state change, otherwise count down and park at zero.
    if (state_d != state_q) begin
      cnt_d = load_cnt(state_d);
    end else if (!cnt_zero_s) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output decode from the current state; registered below.
  always_comb begin
    addr_d  = 2'b00;
    data_d  = 8'h00;
    busy_d  = (state_q != ST_IDLE);
    done_d  = (state_q == ST_DONE);
    // Ready drops on the accepting edge so a held valid is not taken twice.
    ready_d = (state_q == ST_IDLE) && !xfer_s;

    case (state_q)
      ST_SETUP_L, ST_HOLD_L: begin
        addr_d = 2'b00;
        data_d = mask_q[7:0];
      end
      ST_STRB_L: begin
        addr_d = 2'b01;
        data_d = mask_q[7:0];
      end
      ST_SETUP_H, ST_HOLD_H: begin
        addr_d = 2'b00;
        data_d = {4'h0, mask_q[11:8]};
      end
      ST_STRB_H: begin
        addr_d = 2'b10;
        data_d = {4'h0, mask_q[11:8]};
      end
      default: begin
        addr_d = 2'b00;
        data_d = 8'h00;
      end
    endcase
  end

  // State, counter, captured mask and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      mask_q  <= 12'h000;
      ready_q <= 1'b0;
      addr_q  <= 2'b00;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      ready_q <= ready_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign addr_o      = addr_q;
  assign data_o      = data_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_rele_cmd_writer.sv
// -----------------------------------------------------------------------------
// tb_rele_cmd_writer
//
// Directed bench for rele_cmd_writer with SETUP=2, STROBE=4, RECOVER=10.
// Each command is issued on a known transfer edge E0; outputs are sampled 1ns
// after every rising edge and stored by edge index k (k=0 is just after E0).
// Expected indices are hand-derived from the timing rules:
//   addr[0] rises at k=1+S=3, high P=4 samples
//   addr[1] rises at k=2+2S+P=10 (full), or k=1+S=3 (high-only)
//   done at k=3+2S+2P+R=25 (full), k=2+S+P+R... = 18 for single-byte commands
// -----------------------------------------------------------------------------
module tb_rele_cmd_writer;

  localparam int S = 2;
  localparam int P = 4;
  localparam int R = 10;
  localparam int MAXK = 63;

  logic        clk;
  logic        reset_i;
  logic        cmd_valid_i;
  logic [11:0] cmd_mask_i;
  logic        cmd_ready_o;
  logic [1:0]  addr_o;
  logic [7:0]  data_o;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] s_addr [0:MAXK];
  logic [7:0] s_data [0:MAXK];
  logic       s_done [0:MAXK];
  logic       s_rdy  [0:MAXK];
  logic       s_busy [0:MAXK];

  rele_cmd_writer #(
    .SETUP_CYC  (S),
    .STROBE_CYC (P),
    .RECOVER_CYC(R),
    .CNT_W      (21)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_mask_i (cmd_mask_i),
    .cmd_ready_o(cmd_ready_o),
    .addr_o     (addr_o),
    .data_o     (data_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input int k);
    s_addr[k] = addr_o;
    s_data[k] = data_o;
    s_done[k] = done_o;
    s_rdy[k]  = cmd_ready_o;
    s_busy[k] = busy_o;
  endtask

  // Bounded wait until cmd_ready is seen high (called 1ns after an edge).
  task automatic wait_ready();
    int t;
    t = 0;
    while (!cmd_ready_o && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!cmd_ready_o) check_eq("ready_wait", 32'd0, 32'd1);
  endtask

  // Issue one command and record n+1 samples. With hold set, valid stays high
  // and the mask switches to mask2 after edge E0+1.
  task automatic run_cmd(input logic [11:0] mask, input int n,
                         input logic hold, input logic [11:0] mask2);
    wait_ready();
    cmd_valid_i = 1'b1;
    cmd_mask_i  = mask;
    @(posedge clk); #1;
    sample(0);
    if (!hold) begin
      cmd_valid_i = 1'b0;
      cmd_mask_i  = 12'hFFF;   // garbage outside a transfer must be ignored
    end
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      sample(k);
      if (hold && k == 1) cmd_mask_i = mask2;
    end
  endtask

  function automatic int count_addr(input logic [1:0] v, input int n);
    int c;
    c = 0;
    for (int k = 0; k <= n; k++) if (s_addr[k] == v) c++;
    return c;
  endfunction

  function automatic int first_addr(input logic [1:0] v, input int n);
    for (int k = 0; k <= n; k++) if (s_addr[k] == v) return k;
    return -1;
  endfunction

  function automatic int count_done(input int n);
    int c;
    c = 0;
    for (int k = 0; k <= n; k++) if (s_done[k]) c++;
    return c;
  endfunction

  function automatic int first_done(input int n);
    for (int k = 0; k <= n; k++) if (s_done[k]) return k;
    return -1;
  endfunction

  initial begin
    int dcnt;
    int acnt;

    reset_i     = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_mask_i  = 12'h000;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_addr",  32'(addr_o),      32'd0);
    check_eq("rst_data",  32'(data_o),      32'h00);
    check_eq("rst_busy",  32'(busy_o),      32'd0);
    check_eq("rst_done",  32'(done_o),      32'd0);
    check_eq("rst_ready", 32'(cmd_ready_o), 32'd0);
    reset_i = 1'b0;
    @(posedge clk); #1;
    check_eq("rel_ready", 32'(cmd_ready_o), 32'd1);

    // Full 12-bit command.
    run_cmd(12'hA5C, 30, 1'b0, 12'h000);
    check_eq("a5c_rdy0",    32'(s_rdy[0]),                 32'd0);
    check_eq("a5c_data1",   32'(s_data[1]),                32'h5C);
    check_eq("a5c_busy1",   32'(s_busy[1]),                32'd1);
    check_eq("a5c_l_rise",  32'(first_addr(2'b01, 30)),    32'd3);
    check_eq("a5c_l_len",   32'(count_addr(2'b01, 30)),    32'd4);
    check_eq("a5c_l_data",  32'(s_data[3]),                32'h5C);
    check_eq("a5c_l_hold",  32'(s_data[7]),                32'h5C);
    check_eq("a5c_h_rise",  32'(first_addr(2'b10, 30)),    32'd10);
    check_eq("a5c_h_len",   32'(count_addr(2'b10, 30)),    32'd4);
    check_eq("a5c_h_data",  32'(s_data[10]),               32'h0A);
    check_eq("a5c_no_11",   32'(count_addr(2'b11, 30)),    32'd0);
    check_eq("a5c_done_k",  32'(first_done(30)),           32'd25);
    check_eq("a5c_done_n",  32'(count_done(30)),           32'd1);
    check_eq("a5c_rdy25",   32'(s_rdy[25]),                32'd0);
    check_eq("a5c_rdy26",   32'(s_rdy[26]),                32'd1);
    check_eq("a5c_rec_dat", 32'(s_data[20]),               32'h00);

    // Low byte only.
    run_cmd(12'h0FF, 22, 1'b0, 12'h000);
    check_eq("0ff_l_rise",  32'(first_addr(2'b01, 22)),    32'd3);
    check_eq("0ff_l_len",   32'(count_addr(2'b01, 22)),    32'd4);
    check_eq("0ff_l_data",  32'(s_data[4]),                32'hFF);
    check_eq("0ff_no_h",    32'(count_addr(2'b10, 22)),    32'd0);
    check_eq("0ff_done_k",  32'(first_done(22)),           32'd18);

    // High nibble only.
    run_cmd(12'h300, 22, 1'b0, 12'h000);
    check_eq("300_h_rise",  32'(first_addr(2'b10, 22)),    32'd3);
    check_eq("300_h_len",   32'(count_addr(2'b10, 22)),    32'd4);
    check_eq("300_h_data",  32'(s_data[3]),                32'h03);
    check_eq("300_no_l",    32'(count_addr(2'b01, 22)),    32'd0);
    check_eq("300_done_k",  32'(first_done(22)),           32'd18);

    // All-zero mask.
    run_cmd(12'h000, 6, 1'b0, 12'h000);
    check_eq("000_no_strb", 32'(count_addr(2'b00, 6)),     32'd7);
    check_eq("000_done_k",  32'(first_done(6)),            32'd1);
    check_eq("000_done_n",  32'(count_done(6)),            32'd1);
    check_eq("000_rdy0",    32'(s_rdy[0]),                 32'd0);
    check_eq("000_rdy1",    32'(s_rdy[1]),                 32'd0);
    check_eq("000_rdy2",    32'(s_rdy[2]),                 32'd1);

    // Valid held high, mask changing mid-command.
    run_cmd(12'hA5C, 31, 1'b1, 12'h0F0);
    check_eq("b2b_l_data",  32'(s_data[4]),                32'h5C);
    check_eq("b2b_h_data",  32'(s_data[11]),               32'h0A);
    check_eq("b2b_done_k",  32'(first_done(31)),           32'd25);
    check_eq("b2b_rdy26",   32'(s_rdy[26]),                32'd1);
    check_eq("b2b_rdy27",   32'(s_rdy[27]),                32'd0);
    check_eq("b2b_2nd_dat", 32'(s_data[28]),               32'hF0);
    check_eq("b2b_2nd_str", 32'(s_addr[30]),               32'd1);
    cmd_valid_i = 1'b0;

    // Reset during STRB_L.
    run_cmd(12'hA5C, 4, 1'b0, 12'h000);
    check_eq("rst_in_strb", 32'(s_addr[4]),                32'd1);
    reset_i = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_addr", 32'(addr_o),                  32'd0);
    check_eq("mid_rst_data", 32'(data_o),                  32'h00);
    check_eq("mid_rst_busy", 32'(busy_o),                  32'd0);
    reset_i = 1'b0;
    dcnt = 0;
    acnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done_o) dcnt++;
      if (addr_o != 2'b00) acnt++;
    end
    check_eq("mid_rst_nodone", 32'(dcnt), 32'd0);
    check_eq("mid_rst_noaddr", 32'(acnt), 32'd0);

    run_cmd(12'h0FF, 22, 1'b0, 12'h000);
    check_eq("post_l_rise", 32'(first_addr(2'b01, 22)),    32'd3);
    check_eq("post_l_data", 32'(s_data[3]),                32'hFF);
    check_eq("post_done_k", 32'(first_done(22)),           32'd18);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
